// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD up/down counter.
//   bcd_digit_t : one 4-bit BCD digit
//   bcd4_t      : four packed BCD digits, element [3] most significant
//   bcd_valid() : 1 when every digit of a bcd4_t is in 0..9
package bcd_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_MAX    = 9;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned IDX_W      = 2;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;
  typedef bcd_digit_t [BCD_DIGITS-1:0] bcd4_t;

  // Any nibble above 9 makes the word an illegal BCD value.
  function automatic logic bcd_valid(input bcd4_t v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (v[IDX_W'(i)] > DIGIT_W'(BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter.
//   en, up, clear, load, load_val : controls driven by the master
//   digits, tc, load_err          : registered status returned by the counter
interface bcd_updown_counter_if;
  import bcd_pkg::*;

  logic  en;
  logic  up;
  logic  clear;
  logic  load;
  bcd4_t load_val;
  bcd4_t digits;
  logic  tc;
  logic  load_err;

  modport master (
    output en, up, clear, load, load_val,
    input  digits, tc, load_err
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output digits, tc, load_err
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled, flags tick on the last value.
//   clk, reset_n : clock and synchronous active-low reset
//   en           : advance the prescaler this cycle (holds when low)
//   restart      : force the prescaler back to 0 on the next edge
//   tick         : high in the enabled cycle where the count equals TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  // Wide enough for the full legal TICK_DIV range (up to 2^26-1).
  localparam int unsigned CNT_W = 26;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Internal strobe consumed in the same cycle by the digit stepper.
  assign tick = en && (cnt_q == CNT_LAST);

  // Next prescale value.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Prescale register.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Four-digit BCD up/down counter stepped by a TICK_DIV prescaler.
//   clk, reset_n : clock and synchronous active-low reset
//   bus.en       : enables prescaler and stepping
//   bus.up       : 1 = count up, 0 = count down
//   bus.clear    : zero the count (highest priority)
//   bus.load     : load bus.load_val if it is valid BCD
//   bus.digits   : registered count, [15:12] most significant
//   bus.tc       : one-cycle pulse when the count wraps
//   bus.load_err : one-cycle pulse when a load is rejected
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bcd_updown_counter_if.slave    bus
);

  logic  tick;
  logic  pre_en;
  logic  pre_restart;
  logic  load_ok;

  bcd4_t digits_q, digits_d;
  logic  tc_q, tc_d;
  logic  load_err_q, load_err_d;

  bcd4_t step_digits;
  logic  carry;

  assign load_ok = bcd_valid(bus.load_val);

  // Clear or any load cycle steals the tick; a rejected load also freezes the prescaler.
  assign pre_en      = bus.en & ~bus.clear & ~bus.load;
  assign pre_restart = bus.clear | (bus.load & load_ok);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pre_en),
    .restart (pre_restart),
    .tick    (tick)
  );

  // Ripple carry/borrow across the digits; a carry out of the top digit is a wrap.
  always_comb begin
    step_digits = digits_q;
    carry       = 1'b1;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (bus.up) begin
          if (digits_q[IDX_W'(i)] == DIGIT_W'(BCD_MAX)) begin
            step_digits[IDX_W'(i)] = '0;
          end else begin
            step_digits[IDX_W'(i)] = digits_q[IDX_W'(i)] + DIGIT_W'(1);
            carry                  = 1'b0;
          end
        end else begin
          if (digits_q[IDX_W'(i)] == '0) begin
            step_digits[IDX_W'(i)] = DIGIT_W'(BCD_MAX);
          end else begin
            step_digits[IDX_W'(i)] = digits_q[IDX_W'(i)] - DIGIT_W'(1);
            carry                  = 1'b0;
          end
        end
      end
    end
  end

  // Next-state: clear > load > tick step > hold.
  always_comb begin
    digits_d   = digits_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (bus.clear) begin
      digits_d = '0;
    end else if (bus.load) begin
      if (load_ok) digits_d   = bus.load_val;
      else         load_err_d = 1'b1;
    end else if (tick) begin
      digits_d = step_digits;
      tc_d     = carry;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits_q   <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      digits_q   <= digits_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: DUT a uses TICK_DIV=4, DUT b uses TICK_DIV=1.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_if bus_a();
  bcd_updown_counter_if bus_b();

  bcd_updown_counter #(.TICK_DIV(4)) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (bus_a.slave)
  );

  bcd_updown_counter #(.TICK_DIV(1)) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (bus_b.slave)
  );

  // Expected digits of DUT b after each cycle of the toggling-enable run.
  localparam logic [15:0] EXP_B [13] = '{
    16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003, 16'h0003,
    16'h0002, 16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
    16'h9999
  };

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.en = 1'b0; bus_a.up = 1'b0; bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0;
    bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.clear = 1'b0; bus_b.load = 1'b0; bus_b.load_val = '0;

    // Reset state, with clear/load also asserted to show reset wins.
    bus_a.load = 1'b1; bus_a.load_val = 16'h1234;
    cyc(2);
    check("rst_digits", 16'(bus_a.digits), 16'h0000);
    check("rst_tc", 16'(bus_a.tc), 16'h0000);
    check("rst_load_err", 16'(bus_a.load_err), 16'h0000);
    bus_a.load = 1'b0;

    // Free count up: one step every 4 cycles, 0010 after 40 cycles.
    rst_a_n = 1'b1; bus_a.en = 1'b1; bus_a.up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      check($sformatf("count_up_%0d", k), 16'(bus_a.digits),
            (k == 40) ? 16'h0010 : 16'(k / 4));
      check($sformatf("count_up_tc_%0d", k), 16'(bus_a.tc), 16'h0000);
    end

    // Load 9998 and run through the up wrap.
    bus_a.load = 1'b1; bus_a.load_val = 16'h9998;
    cyc(1);
    bus_a.load = 1'b0;
    check("load_9998", 16'(bus_a.digits), 16'h9998);
    cyc(4); check("up_9999", 16'(bus_a.digits), 16'h9999);
    cyc(3); check("up_pre_wrap", 16'(bus_a.digits), 16'h9999);
    check("up_pre_wrap_tc", 16'(bus_a.tc), 16'h0000);
    cyc(1); check("up_wrap", 16'(bus_a.digits), 16'h0000);
    check("up_wrap_tc", 16'(bus_a.tc), 16'h0001);
    cyc(1); check("up_wrap_tc_end", 16'(bus_a.tc), 16'h0000);
    cyc(3); check("up_0001", 16'(bus_a.digits), 16'h0001);

    // Down count with borrow, then down wrap.
    bus_a.up = 1'b0; bus_a.load = 1'b1; bus_a.load_val = 16'h0100;
    cyc(1);
    bus_a.load = 1'b0;
    check("load_0100", 16'(bus_a.digits), 16'h0100);
    cyc(4); check("dn_0099", 16'(bus_a.digits), 16'h0099);
    cyc(4); check("dn_0098", 16'(bus_a.digits), 16'h0098);
    bus_a.load = 1'b1; bus_a.load_val = 16'h0000;
    cyc(1);
    bus_a.load = 1'b0;
    cyc(4); check("dn_wrap", 16'(bus_a.digits), 16'h9999);
    check("dn_wrap_tc", 16'(bus_a.tc), 16'h0001);
    cyc(1); check("dn_wrap_tc_end", 16'(bus_a.tc), 16'h0000);

    // Rejected load: digits and prescaler (now 1) hold, load_err pulses once.
    bus_a.load = 1'b1; bus_a.load_val = 16'h12A4;
    cyc(1);
    bus_a.load = 1'b0;
    check("bad_load_digits", 16'(bus_a.digits), 16'h9999);
    check("bad_load_err", 16'(bus_a.load_err), 16'h0001);
    cyc(1); check("bad_load_err_end", 16'(bus_a.load_err), 16'h0000);
    cyc(1); check("bad_load_hold_pre", 16'(bus_a.digits), 16'h9999);
    cyc(1); check("bad_load_step", 16'(bus_a.digits), 16'h9998);

    // Clear beats load.
    bus_a.clear = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 16'h1234;
    cyc(1);
    bus_a.clear = 1'b0; bus_a.load = 1'b0;
    check("clear_load", 16'(bus_a.digits), 16'h0000);
    check("clear_load_err", 16'(bus_a.load_err), 16'h0000);
    check("clear_tc", 16'(bus_a.tc), 16'h0000);

    // Reset on the tick cycle discards the step and the partial prescale.
    bus_a.up = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 16'h0005;
    cyc(1);
    bus_a.load = 1'b0;
    check("load_0005", 16'(bus_a.digits), 16'h0005);
    cyc(3);
    rst_a_n = 1'b0;
    cyc(1);
    rst_a_n = 1'b1;
    check("rst_on_tick", 16'(bus_a.digits), 16'h0000);
    check("rst_on_tick_tc", 16'(bus_a.tc), 16'h0000);
    cyc(3); check("rst_no_early_step", 16'(bus_a.digits), 16'h0000);
    cyc(1); check("rst_first_step", 16'(bus_a.digits), 16'h0001);

    // TICK_DIV=1: step on every enabled cycle, direction flips mid-run.
    rst_b_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus_b.en = (i % 2 == 0);
      bus_b.up = (i < 6);
      cyc(1);
      check($sformatf("div1_%0d", i), 16'(bus_b.digits), EXP_B[i]);
      check($sformatf("div1_tc_%0d", i), 16'(bus_b.tc), (i == 12) ? 16'h0001 : 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per count step (legal range 1 to 2^26-1).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port en  input  1  count enable, gates prescaler and stepping.
REQ-005 SHALL have port up  input  1  direction, 1 = increment, 0 = decrement.
REQ-006 SHALL have port clear  input  1  synchronous clear of count to 0000.
REQ-007 SHALL have port load  input  1  load request for load_val.
REQ-008 SHALL have port load_val  input  16  four BCD digits, [15:12] most significant.
REQ-009 SHALL have port digits  output  16  registered count, one 4-bit BCD digit per 7-segment decoder, [15:12] most significant.
REQ-010 SHALL have port tc  output  1  one-cycle terminal-count pulse on wrap.
REQ-011 SHALL have port load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 while en=1, assert internal tick in the cycle it equals TICK_DIV-1, then return to 0.
REQ-013 Prescaler SHALL hold its value while en=0. No tick while en=0.
REQ-014 TICK_DIV=1 SHALL produce a tick every cycle that en=1.
REQ-015 Per-cycle priority SHALL be clear > load > tick step > hold.
REQ-016 clear=1 SHALL set digits=0000 and prescaler=0 next cycle. No tc and no load_err that cycle.
REQ-017 For load=1 with every load_val nibble <=9, digits SHALL equal load_val next cycle and prescaler SHALL be 0.
REQ-018 For load=1 with any nibble >9, the load SHALL be rejected: digits and prescaler unchanged, load_err=1 for exactly the next cycle.
REQ-019 A tick with up=1 SHALL increment the count as decimal: a digit at 9 goes to 0 and carries into the next digit. Digits never hold 0xA-0xF.
REQ-020 A tick with up=0 SHALL decrement the count as decimal: a digit at 0 goes to 9 and borrows from the next digit.
REQ-021 Up-stepping at 9999 SHALL wrap to 0000. Down-stepping at 0000 SHALL wrap to 9999. Either wrap SHALL pulse tc=1 in the same cycle digits shows the wrapped value.
REQ-022 Step latency SHALL be 1 cycle: digits updates on the edge following the tick cycle.
REQ-023 Changing up between ticks SHALL take effect on the next tick. A direction change is never lost or delayed.
REQ-024 A load or clear coinciding with a tick SHALL suppress that step, and tc SHALL stay 0.
REQ-025 digits, tc and load_err SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-026 With reset_n=0 at a rising edge, the block SHALL set digits=0000, tc=0, load_err=0 and prescaler=0 at that edge.
REQ-027 reset_n SHALL override clear, load and tick. Reset mid-count SHALL discard any partial prescale.
REQ-028 The first step after reset release SHALL occur TICK_DIV enabled cycles later.

Structure
REQ-029 Package bcd_pkg SHALL hold typedef bcd_digit_t (4-bit), typedef bcd4_t (array of 4 bcd_digit_t), and constants BCD_MAX=9 and BCD_DIGITS=4.
REQ-030 The prescaler SHALL be the sub-module tick_gen, parameterised by TICK_DIV, with ports clk, reset_n, en, restart and tick.
REQ-031 Digit stepping SHALL be a carry/borrow chain over the BCD_DIGITS digits, with no binary-to-BCD conversion.
REQ-032 Target size SHALL be 120-400 lines of RTL, including the package and tick_gen.

Verification (TICK_DIV=4 unless stated)
REQ-033 Reset, then en=1, up=1 for 40 cycles -> digits steps 0000, 0001, ... every 4 cycles and reaches 0010 after 40 cycles.
REQ-034 Load 9998, up=1, en=1 -> 9999, then 0000 with tc=1 for exactly one cycle, then 0001.
REQ-035 Load 0100, up=0 -> 0099, then 0098. Load 0000, up=0 -> 9999 with a tc pulse.
REQ-036 Load 12A4 -> digits unchanged and load_err=1 for one cycle. clear and load asserted together -> digits=0000.
REQ-037 Count 0005, assert reset_n=0 on the tick cycle -> digits=0000 next edge, and the next step comes 4 enabled cycles after reset release.
REQ-038 TICK_DIV=1, en toggled every other cycle, up toggled mid-run -> the count steps exactly once per enabled cycle in the current direction.
